// File: rtl/mux_2to1_buf.sv
// Merges two valid-qualified byte lanes into one registered stream on clk_2f.
// Each lane is buffered by a small FIFO; a round-robin arbiter drains one word per cycle.
module mux_2to1_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  input  logic                  valid_in_0,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic                  valid_in_1,
  output logic [DATA_WIDTH-1:0] data_mux,
  output logic                  valid_mux,
  output logic                  fifo_full_0,
  output logic                  fifo_full_1,
  output logic                  fifo_empty_0,
  output logic                  fifo_empty_1,
  output logic                  overflow_err
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem0_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem1_q [FIFO_DEPTH];

  logic [ADDR_WIDTH:0]   wptr0_q, rptr0_q, wptr1_q, rptr1_q;
  logic [ADDR_WIDTH:0]   cnt0, cnt1;
  logic                  full0, full1, empty0, empty1;
  logic                  rd0, rd1, wr0, wr1, drop;

  logic                  last_sel_q, last_sel_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;

  // Occupancy from pointers; the extra MSB separates full from empty.
  assign cnt0   = wptr0_q - rptr0_q;
  assign cnt1   = wptr1_q - rptr1_q;
  assign full0  = (cnt0 == FULL_CNT);
  assign full1  = (cnt1 == FULL_CNT);
  assign empty0 = (cnt0 == '0);
  assign empty1 = (cnt1 == '0);

  always_comb begin
    rd0 = 1'b0;
    rd1 = 1'b0;
    if (!empty0 && !empty1) begin
      rd0 = last_sel_q;
      rd1 = !last_sel_q;
    end else begin
      rd0 = !empty0;
      rd1 = !empty1;
    end
  end

  // A full lane still accepts a write when the arbiter frees its head slot this edge.
  assign wr0  = valid_in_0 && (!full0 || rd0);
  assign wr1  = valid_in_1 && (!full1 || rd1);
  assign drop = (valid_in_0 && full0 && !rd0) || (valid_in_1 && full1 && !rd1);

  always_comb begin
    data_d     = '0;
    valid_d    = 1'b0;
    last_sel_d = last_sel_q;
    ovf_d      = ovf_q | drop;
    if (rd0) begin
      data_d     = mem0_q[rptr0_q[ADDR_WIDTH-1:0]];
      valid_d    = 1'b1;
      last_sel_d = 1'b0;
    end else if (rd1) begin
      data_d     = mem1_q[rptr1_q[ADDR_WIDTH-1:0]];
      valid_d    = 1'b1;
      last_sel_d = 1'b1;
    end
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      wptr0_q    <= '0;
      rptr0_q    <= '0;
      wptr1_q    <= '0;
      rptr1_q    <= '0;
      last_sel_q <= 1'b1;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (wr0) wptr0_q <= wptr0_q + PTR_ONE;
      if (rd0) rptr0_q <= rptr0_q + PTR_ONE;
      if (wr1) wptr1_q <= wptr1_q + PTR_ONE;
      if (rd1) rptr1_q <= rptr1_q + PTR_ONE;
      last_sel_q <= last_sel_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage arrays carry no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk_2f) begin
    if (wr0) mem0_q[wptr0_q[ADDR_WIDTH-1:0]] <= data_in_0;
    if (wr1) mem1_q[wptr1_q[ADDR_WIDTH-1:0]] <= data_in_1;
  end

  assign data_mux     = data_q;
  assign valid_mux    = valid_q;
  assign overflow_err = ovf_q;
  assign fifo_full_0  = full0;
  assign fifo_full_1  = full1;
  assign fifo_empty_0 = empty0;
  assign fifo_empty_1 = empty1;

endmodule

// File: tb/tb_mux_2to1_buf.sv
// Bench for mux_2to1_buf: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mux_2to1_buf;

  localparam int DEPTH = 4;

  logic       clk_2f;
  logic       reset;
  logic [7:0] data_in_0, data_in_1;
  logic       valid_in_0, valid_in_1;
  logic [7:0] data_mux;
  logic       valid_mux;
  logic       fifo_full_0, fifo_full_1, fifo_empty_0, fifo_empty_1;
  logic       overflow_err;

  mux_2to1_buf #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(2)) dut (
    .clk_2f      (clk_2f),
    .reset       (reset),
    .data_in_0   (data_in_0),
    .valid_in_0  (valid_in_0),
    .data_in_1   (data_in_1),
    .valid_in_1  (valid_in_1),
    .data_mux    (data_mux),
    .valid_mux   (valid_mux),
    .fifo_full_0 (fifo_full_0),
    .fifo_full_1 (fifo_full_1),
    .fifo_empty_0(fifo_empty_0),
    .fifo_empty_1(fifo_empty_1),
    .overflow_err(overflow_err)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         last_lane;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int n0, n1, rd;
    if (reset) begin
      q0.delete();
      q1.delete();
      m_data = 8'h00;
      m_valid = 1'b0;
      m_ovf = 1'b0;
      last_lane = 1;
      return;
    end
    n0 = q0.size();
    n1 = q1.size();
    rd = -1;
    if (n0 > 0 && n1 > 0) rd = (last_lane == 0) ? 1 : 0;
    else if (n0 > 0)      rd = 0;
    else if (n1 > 0)      rd = 1;
    m_data  = 8'h00;
    m_valid = 1'b0;
    if (rd == 0) begin
      m_data = q0.pop_front();
      m_valid = 1'b1;
      last_lane = 0;
    end else if (rd == 1) begin
      m_data = q1.pop_front();
      m_valid = 1'b1;
      last_lane = 1;
    end
    if (valid_in_0) begin
      if (n0 < DEPTH || rd == 0) q0.push_back(data_in_0);
      else m_ovf = 1'b1;
    end
    if (valid_in_1) begin
      if (n1 < DEPTH || rd == 1) q1.push_back(data_in_1);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic compare_model();
    chk("model data_mux", data_mux, m_data);
    chk("model valid_mux", valid_mux, m_valid);
    chk("model overflow_err", overflow_err, m_ovf);
    chk("model fifo_empty_0", fifo_empty_0, q0.size() == 0);
    chk("model fifo_empty_1", fifo_empty_1, q1.size() == 0);
    chk("model fifo_full_0", fifo_full_0, q0.size() == DEPTH);
    chk("model fifo_full_1", fifo_full_1, q1.size() == DEPTH);
  endtask

  // One clock edge: drive on the falling edge, update model at the rising edge, check just after.
  task automatic step(input logic r, input logic a0, input logic [7:0] b0,
                      input logic a1, input logic [7:0] b1);
    @(negedge clk_2f);
    reset = r;
    valid_in_0 = a0;
    data_in_0 = b0;
    valid_in_1 = a1;
    data_in_1 = b1;
    @(posedge clk_2f);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] bl_exp [6];
    logic [7:0] l1_seen[$];
    logic [7:0] l1_exp [8];
    logic       saw_full1;
    int         p0, p1;

    reset = 1'b0;
    valid_in_0 = 1'b0;
    valid_in_1 = 1'b0;
    data_in_0 = 8'h00;
    data_in_1 = 8'h00;
    last_lane = 1;
    m_data = 8'h00;
    m_valid = 1'b0;
    m_ovf = 1'b0;

    // Reset with a write attempt on lane 0
    step(1'b1, 1'b1, 8'hAA, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'hAA, 1'b0, 8'h00);
    chk("rst valid_mux", valid_mux, 1'b0);
    chk("rst data_mux", data_mux, 8'h00);
    chk("rst empty_0", fifo_empty_0, 1'b1);
    chk("rst empty_1", fifo_empty_1, 1'b1);
    chk("rst full_0", fifo_full_0, 1'b0);
    chk("rst overflow", overflow_err, 1'b0);
    idle();
    chk("rst AA not stored valid", valid_mux, 1'b0);
    chk("rst AA not stored empty", fifo_empty_0, 1'b1);

    // Single-lane stream
    step(1'b0, 1'b1, 8'h01, 1'b0, 8'h00);
    chk("single k valid", valid_mux, 1'b0);
    step(1'b0, 1'b1, 8'h02, 1'b0, 8'h00);
    chk("single k+1 data", data_mux, 8'h01);
    chk("single k+1 valid", valid_mux, 1'b1);
    step(1'b0, 1'b1, 8'h03, 1'b0, 8'h00);
    chk("single k+2 data", data_mux, 8'h02);
    idle();
    chk("single k+3 data", data_mux, 8'h03);
    chk("single k+3 valid", valid_mux, 1'b1);
    idle();
    chk("single k+4 valid", valid_mux, 1'b0);

    // Both lanes backlogged, alternating from lane 0
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    bl_exp = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
    for (int i = 0; i < 8; i++) begin
      if (i < 3) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b1, 8'(8'h20 + i));
      else idle();
      if (i == 0) chk("backlog k valid", valid_mux, 1'b0);
      else if (i <= 6) begin
        chk("backlog data", data_mux, bl_exp[i-1]);
        chk("backlog valid", valid_mux, 1'b1);
      end else begin
        chk("backlog end valid", valid_mux, 1'b0);
        chk("backlog end empty_0", fifo_empty_0, 1'b1);
        chk("backlog end empty_1", fifo_empty_1, 1'b1);
      end
    end

    // Overflow: both lanes write every edge for 10 edges
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    saw_full1 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i < 10) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b1, 8'(8'h30 + i));
      else idle();
      if (fifo_full_1) saw_full1 = 1'b1;
      if (valid_mux && data_mux[7:4] == 4'h3) l1_seen.push_back(data_mux);
      if (i == 5) chk("ovf full_1 at e5", fifo_full_1, 1'b1);
      if (i == 6) chk("ovf not yet at e6", overflow_err, 1'b0);
      if (i >= 7) chk("ovf sticky", overflow_err, 1'b1);
    end
    chk("ovf saw full_1", saw_full1, 1'b1);
    l1_exp = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h38};
    chk("ovf lane1 survivor count", l1_seen.size(), 8);
    for (int i = 0; i < 8 && i < l1_seen.size(); i++)
      chk("ovf lane1 survivor order", l1_seen[i], l1_exp[i]);

    // Lane 0 full, lane 1 empty, write accepted via concurrent read
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b1, 8'(8'hA0 + i), (i < 3), 8'(8'hB0 + i));
    chk("fullrd pre full_0", fifo_full_0, 1'b1);
    chk("fullrd pre empty_1", fifo_empty_1, 1'b1);
    step(1'b0, 1'b1, 8'h55, 1'b0, 8'h00);
    chk("fullrd count stays full", fifo_full_0, 1'b1);
    chk("fullrd no overflow", overflow_err, 1'b0);
    chk("fullrd data A3", data_mux, 8'hA3);
    idle();
    idle();
    idle();
    chk("fullrd data A6", data_mux, 8'hA6);
    idle();
    chk("fullrd 55 last data", data_mux, 8'h55);
    chk("fullrd 55 last valid", valid_mux, 1'b1);
    idle();
    chk("fullrd drained valid", valid_mux, 1'b0);

    // Reset mid-operation with 3 words per lane
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b1, 8'(8'hD0 + i));
    chk("midrst pre empty_0", fifo_empty_0, 1'b0);
    chk("midrst pre full_0", fifo_full_0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    chk("midrst valid", valid_mux, 1'b0);
    chk("midrst empty_0", fifo_empty_0, 1'b1);
    chk("midrst empty_1", fifo_empty_1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'h77);
    chk("midrst write edge valid", valid_mux, 1'b0);
    idle();
    chk("midrst first out data", data_mux, 8'h77);
    chk("midrst first out valid", valid_mux, 1'b1);
    idle();
    chk("midrst after valid", valid_mux, 1'b0);

    // Randomized traffic with varying load and occasional reset
    p0 = 50;
    p1 = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) begin
        p0 = int'($urandom_range(0, 100));
        p1 = int'($urandom_range(0, 100));
      end
      step(($urandom_range(0, 249) == 0),
           (int'($urandom_range(0, 99)) < p0), 8'($urandom),
           (int'($urandom_range(0, 99)) < p1), 8'($urandom));
    end
    for (int c = 0; c < 12; c++) idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
